fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch stage. It sits directly upstream of decode_stage and replaces the constant instruction
//  currently tied to decode's inst input. It owns the PC and issues word reads to the instruction memory
//  (1-cycle synchronous read latency). Returned words are buffered in a small FIFO, and the FIFO head is
//  presented to decode through a valid/ready handshake. Branch redirect, pipeline stall and sleep (SLP)
//  are all honoured.
// PARAMETERS
//  RESET_PC  16'h0000  fetch address after reset; bit 0 ignored
//  DEPTH     4         FIFO entries, power of 2, >=2
// PORTS
//  clk_in         in   1   pipeline clock
//  reset          in   1   asynchronous, active-high
//  stall          in   1   pipeline_controller stall (OR of stall bits); blocks pop only
//  branch_taken   in   1   redirect request from execute, single-cycle pulse
//  branch_target  in   16  redirect byte address
//  sleep          in   1   SLP from decode; enter SLEEP
//  wake           in   1   leave SLEEP (interrupt/debug)
//  imem_addr      out  16  read address, always even
//  imem_rd        out  1   read strobe; data valid on imem_rdata next cycle
//  imem_rdata     in   16  read data
//  inst           out  16  instruction at FIFO head (to decode_stage.inst)
//  inst_pc        out  16  byte address of inst
//  inst_valid     out  1   FIFO not empty
//  inst_ready     in   1   decode can accept
//  pc             out  16  next fetch address
// BEHAVIOUR
//  Reset values:
//   - pc=RESET_PC&~1; imem_rd=0; imem_addr=0; inst=0; inst_pc=0; inst_valid=0.
//   - FIFO empty, all entries zeroed; state=BOOT; epoch=0.
//  FSM:
//   - BOOT->RUN after exactly one cycle, with no fetch in BOOT.
//   - RUN->SLEEP when sleep=1; SLEEP->RUN on wake=1 or branch_taken=1.
//  Issue (RUN only):
//   - imem_rd=1 iff count+inflight-pop < DEPTH.
//   - On issue: imem_addr=pc and pc<=pc+2, mod 2^16 (16'hFFFE wraps to 16'h0000).
//  Response: the cycle after an issue, {epoch-tag, pc, imem_rdata} is pushed if its tag equals the
//   current epoch. Otherwise it is dropped.
//  Pop: pop = inst_valid & inst_ready & ~stall; it advances the head. inst and inst_pc are combinational
//   from the head entry. While inst_valid=0, inst and inst_pc hold the last-popped values.
//  Latency: imem_rd (cycle N) -> inst_valid=1 (cycle N+2); no bypass. Throughput is 1 inst/cycle with
//   inst_ready=1 and stall=0.
//  Branch (highest priority):
//   - Cycle of branch_taken: FIFO flushed (count=0), epoch toggles, no issue.
//   - pc <= branch_target & ~1.
//   - Next cycle: issue from the target.
//  Simultaneous events:
//   - branch + pop: flush wins, and the popped entry is still consumed that cycle.
//   - branch + sleep: branch wins, state=RUN.
//   - push + pop with FIFO full: legal, count unchanged.
//  Sleep:
//   - No new issues; an in-flight response is still pushed; the FIFO drains normally.
//   - pc is frozen, and fetch resumes at pc on wake.
//  Boundaries:
//   - count never exceeds DEPTH, guaranteed by the issue credit rule.
//   - stall=1 with FIFO full: imem_rd=0, no data lost.
//  Reset mid-operation: all state returns to reset values immediately; an in-flight response is ignored.
// TESTING
//  1. Reset release, RESET_PC=0, imem returns addr-derived data, inst_ready=1 -> inst_valid at cycle 3;
//     inst_pc 0,2,4,... on consecutive cycles.
//  2. inst_ready=0 for 10 cycles -> exactly DEPTH entries buffered, imem_rd=0 once full;
//     release -> in-order delivery, no loss or duplication.
//  3. branch_taken with target 16'h1235 while FIFO holds 3 and 1 read is in flight -> flushed;
//     first inst_pc=16'h1234; stale data never appears.
//  4. pc=16'hFFFC, free-running -> fetch addresses FFFC, FFFE, 0000, 0002.
//  5. sleep pulse -> issues stop, FIFO drains; wake 5 cycles later -> fetch resumes at frozen pc.
//  6. reset asserted while imem_rd=1 and FIFO non-empty -> outputs at reset values immediately;
//     stale response not pushed.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction fetch stage feeding decode_stage. Owns the PC, issues one
//   16-bit word read per cycle to a synchronous instruction memory (data one
//   cycle after the strobe), buffers returned words in a small FIFO and
//   presents the FIFO head to decode over a valid/ready handshake.
//   Branch redirect, pipeline stall and sleep (SLP) are honoured.
//
// Ports
//   clk_in, reset        pipeline clock, asynchronous active-high reset
//   stall                pipeline stall; only blocks the pop to decode
//   branch_taken         single-cycle redirect pulse from execute
//   branch_target        redirect byte address (bit 0 ignored)
//   sleep / wake         enter / leave the SLEEP state
//   imem_addr, imem_rd   read request; imem_addr is 0 when no read is issued
//   imem_rdata           read data, valid the cycle after imem_rd
//   inst, inst_pc        instruction and its byte address at the FIFO head
//                        (last popped values while the FIFO is empty)
//   inst_valid           FIFO not empty
//   inst_ready           decode can accept
//   pc                   next fetch address
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        sleep,
  input  logic        wake,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_rdata,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [15:0] pc
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]  DEPTH_W = (CNT_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    SLEEP = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [15:0]        pc_reg, pc_next;
  logic               epoch_reg;

  // One outstanding read at most: the request issued last cycle.
  logic               inflight_reg;
  logic               inflight_tag_reg;
  logic [15:0]        inflight_pc_reg;

  logic [PTR_W-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [15:0]        fifo_inst_reg [DEPTH];
  logic [15:0]        fifo_pc_reg   [DEPTH];

  logic [15:0]        last_inst_reg, last_pc_reg;

  logic               pop, push;
  logic [CNT_W:0]     occupancy;

  assign inst_valid = (count_reg != '0);
  assign pop        = inst_valid & inst_ready & ~stall;

  // A response from before a redirect carries the old epoch and is dropped.
  // The response arriving in the redirect cycle itself is also dropped, since
  // the flush wins over the push.
  assign push = inflight_reg & (inflight_tag_reg == epoch_reg) & ~branch_taken;

  // Entries that will be held next cycle if nothing new is issued; issuing is
  // allowed only while this leaves room for the new response.
  assign occupancy = {1'b0, count_reg}
                   + {{CNT_W{1'b0}}, inflight_reg}
                   - {{CNT_W{1'b0}}, pop};

  assign inst    = inst_valid ? fifo_inst_reg[rd_ptr_reg] : last_inst_reg;
  assign inst_pc = inst_valid ? fifo_pc_reg[rd_ptr_reg]   : last_pc_reg;
  assign pc      = pc_reg;

  // Next state and fetch outputs.
  always_comb begin
    state_next = state_reg;
    imem_rd    = 1'b0;
    imem_addr  = 16'h0000;
    pc_next    = pc_reg;

    case (state_reg)
      BOOT:    state_next = RUN;
      RUN:     if (sleep) state_next = SLEEP;
      SLEEP:   if (wake)  state_next = RUN;
      default: state_next = BOOT;
    endcase

    if (state_reg == RUN && !branch_taken && occupancy < DEPTH_W) begin
      imem_rd   = 1'b1;
      imem_addr = pc_reg;
      pc_next   = pc_reg + 16'd2;
    end

    if (branch_taken) begin
      state_next = RUN;
      pc_next    = branch_target & 16'hFFFE;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_reg        <= BOOT;
      pc_reg           <= RESET_PC & 16'hFFFE;
      epoch_reg        <= 1'b0;
      inflight_reg     <= 1'b0;
      inflight_tag_reg <= 1'b0;
      inflight_pc_reg  <= 16'h0000;
      rd_ptr_reg       <= '0;
      wr_ptr_reg       <= '0;
      count_reg        <= '0;
      last_inst_reg    <= 16'h0000;
      last_pc_reg      <= 16'h0000;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_inst_reg[i] <= 16'h0000;
        fifo_pc_reg[i]   <= 16'h0000;
      end
    end else begin
      state_reg        <= state_next;
      pc_reg           <= pc_next;
      inflight_reg     <= imem_rd;
      inflight_tag_reg <= epoch_reg;
      inflight_pc_reg  <= pc_reg;

      // The popped entry is consumed even when a redirect flushes the FIFO
      // in the same cycle, so it still becomes the held output.
      if (pop) begin
        last_inst_reg <= fifo_inst_reg[rd_ptr_reg];
        last_pc_reg   <= fifo_pc_reg[rd_ptr_reg];
      end

      if (push) begin
        fifo_inst_reg[wr_ptr_reg] <= imem_rdata;
        fifo_pc_reg[wr_ptr_reg]   <= inflight_pc_reg;
      end

      if (branch_taken) begin
        epoch_reg  <= ~epoch_reg;
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop);
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(push);
        count_reg  <= count_reg + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed table, hand-written corner sequences
// and a randomized run, all checked against a queue-based reference model.
module tb_fetch_stage;

  localparam int DEPTH = 4;

  logic        clk_in        = 1'b0;
  logic        reset         = 1'b1;
  logic        stall         = 1'b0;
  logic        branch_taken  = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic        sleep         = 1'b0;
  logic        wake          = 1'b0;
  logic        inst_ready    = 1'b0;
  logic [15:0] imem_rdata    = 16'h0000;
  logic [15:0] imem_addr, inst, inst_pc, pc;
  logic        imem_rd, inst_valid;

  int checks   = 0;
  int failures = 0;

  fetch_stage #(.RESET_PC(16'h0000), .DEPTH(DEPTH)) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .sleep         (sleep),
    .wake          (wake),
    .imem_addr     (imem_addr),
    .imem_rd       (imem_rd),
    .imem_rdata    (imem_rdata),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .pc            (pc)
  );

  always #5 clk_in = ~clk_in;

  // Address-derived memory contents.
  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clk_in) if (imem_rd) imem_rdata <= memf(imem_addr);

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] ipc;
    logic [15:0] idata;
  } entry_t;

  entry_t      mq[$];
  int          m_state;      // 0 boot, 1 run, 2 sleep
  logic [15:0] m_pc;
  logic [15:0] m_last_inst, m_last_pc;
  bit          m_infl;
  logic [15:0] m_infl_pc;

  task automatic model_reset();
    mq.delete();
    m_state     = 0;
    m_pc        = 16'h0000;
    m_last_inst = 16'h0000;
    m_last_pc   = 16'h0000;
    m_infl      = 0;
    m_infl_pc   = 16'h0000;
  endtask

  // Called mid-cycle with this cycle's inputs applied: checks DUT outputs and
  // advances the model to the next cycle.
  task automatic model_step();
    bit          v, p, iss;
    int          occ;
    logic [15:0] e_inst, e_ipc, e_addr;
    v      = (mq.size() != 0);
    e_inst = v ? mq[0].idata : m_last_inst;
    e_ipc  = v ? mq[0].ipc   : m_last_pc;
    p      = v && inst_ready && !stall;
    occ    = mq.size() + (m_infl ? 1 : 0) - (p ? 1 : 0);
    iss    = (m_state == 1) && !branch_taken && (occ < DEPTH);
    e_addr = iss ? m_pc : 16'h0000;

    chk("m_inst_valid", 16'(inst_valid), 16'(v));
    chk("m_inst",       inst,            e_inst);
    chk("m_inst_pc",    inst_pc,         e_ipc);
    chk("m_imem_rd",    16'(imem_rd),    16'(iss));
    chk("m_imem_addr",  imem_addr,       e_addr);
    chk("m_pc",         pc,              m_pc);

    if (p) begin
      $display("pop pc=%h inst=%h", mq[0].ipc, mq[0].idata);
      m_last_inst = mq[0].idata;
      m_last_pc   = mq[0].ipc;
      void'(mq.pop_front());
    end
    if (branch_taken) begin
      mq.delete();
      m_pc    = branch_target & 16'hFFFE;
      m_state = 1;
      m_infl  = 0;
    end else begin
      if (m_infl) mq.push_back('{m_infl_pc, memf(m_infl_pc)});
      if (m_state == 0)                 m_state = 1;
      else if (m_state == 1 && sleep)   m_state = 2;
      else if (m_state == 2 && wake)    m_state = 1;
      m_infl    = iss;
      m_infl_pc = m_pc;
      if (iss) m_pc = m_pc + 16'd2;
    end
  endtask

  task automatic apply(input logic s, input logic b, input logic [15:0] t,
                       input logic sl, input logic w, input logic r);
    stall = s; branch_taken = b; branch_target = t; sleep = sl; wake = w; inst_ready = r;
    #4;
    model_step();
  endtask

  task automatic adv();
    @(posedge clk_in);
    #1;
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic        rdy;
    logic        exp_rd;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_ipc;
  } vec_t;

  vec_t        tbl[20];
  logic [15:0] exp4[4];
  logic [15:0] frozen;
  int          k;

  initial begin
    // Reset release, in-order streaming, then 10 cycles of inst_ready=0.
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
    tbl[2]  = '{1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000};
    tbl[3]  = '{1'b1, 1'b1, 16'h0004, 1'b1, 16'h0000};
    tbl[4]  = '{1'b1, 1'b1, 16'h0006, 1'b1, 16'h0002};
    tbl[5]  = '{1'b1, 1'b1, 16'h0008, 1'b1, 16'h0004};
    tbl[6]  = '{1'b0, 1'b1, 16'h000A, 1'b1, 16'h0006};
    tbl[7]  = '{1'b0, 1'b1, 16'h000C, 1'b1, 16'h0006};
    for (int i = 8; i < 16; i++) tbl[i] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006};
    tbl[16] = '{1'b1, 1'b1, 16'h000E, 1'b1, 16'h0006};
    tbl[17] = '{1'b1, 1'b1, 16'h0010, 1'b1, 16'h0008};
    tbl[18] = '{1'b1, 1'b1, 16'h0012, 1'b1, 16'h000A};
    tbl[19] = '{1'b1, 1'b1, 16'h0014, 1'b1, 16'h000C};
    exp4[0] = 16'hFFFC; exp4[1] = 16'hFFFE; exp4[2] = 16'h0000; exp4[3] = 16'h0002;

    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_imem_rd",    16'(imem_rd),    16'h0000);
    chk("rst_imem_addr",  imem_addr,       16'h0000);
    chk("rst_inst_valid", 16'(inst_valid), 16'h0000);
    chk("rst_inst",       inst,            16'h0000);
    chk("rst_inst_pc",    inst_pc,         16'h0000);
    chk("rst_pc",         pc,              16'h0000);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, tbl[i].rdy);
      chk("tbl_imem_rd",    16'(imem_rd),    16'(tbl[i].exp_rd));
      chk("tbl_imem_addr",  imem_addr,       tbl[i].exp_addr);
      chk("tbl_inst_valid", 16'(inst_valid), 16'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        chk("tbl_inst_pc", inst_pc, tbl[i].exp_ipc);
        chk("tbl_inst",    inst,    memf(tbl[i].exp_ipc));
      end
      adv();
    end

    // Redirect with 3 buffered and 1 in flight; the head is popped in the
    // redirect cycle.
    k = 0;
    while (!(mq.size() == 3 && m_infl) && k < 12) begin
      apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      adv();
      k++;
    end
    apply(1'b0, 1'b1, 16'h1235, 1'b0, 1'b0, 1'b1);
    chk("br_no_issue", 16'(imem_rd), 16'h0000);
    adv();
    apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("br_rd_target",   16'(imem_rd),    16'h0001);
    chk("br_addr_target", imem_addr,       16'h1234);
    chk("br_flushed",     16'(inst_valid), 16'h0000);
    chk("br_last_popped", inst_pc,         16'h000E);
    adv();
    apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("br_no_stale", 16'(inst_valid), 16'h0000);
    adv();
    apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("br_first_valid", 16'(inst_valid), 16'h0001);
    chk("br_first_pc",    inst_pc,         16'h1234);
    chk("br_first_inst",  inst,            memf(16'h1234));
    adv();

    // PC wrap at the top of the address space.
    apply(1'b0, 1'b1, 16'hFFFC, 1'b0, 1'b0, 1'b1);
    adv();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("wrap_rd",   16'(imem_rd), 16'h0001);
      chk("wrap_addr", imem_addr,    exp4[i]);
      adv();
    end

    // Sleep pulse, drain, wake after 5 cycles.
    apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    adv();
    frozen = m_pc;
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("sleep_no_issue", 16'(imem_rd), 16'h0000);
      chk("sleep_pc_frozen", pc, frozen);
      if (i == 4) chk("sleep_drained", 16'(inst_valid), 16'h0000);
      adv();
    end
    apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    chk("wake_cycle_no_issue", 16'(imem_rd), 16'h0000);
    adv();
    apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("wake_resume_rd",   16'(imem_rd), 16'h0001);
    chk("wake_resume_addr", imem_addr,    frozen);
    adv();

    // Reset while a read is issued and the FIFO holds data.
    k = 0;
    while (!(imem_rd && inst_valid) && k < 10) begin
      apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      adv();
      k++;
    end
    chk("mid_rst_setup", 16'(imem_rd & inst_valid), 16'h0001);
    reset = 1'b1;
    #1;
    chk("mid_rst_imem_rd",    16'(imem_rd),    16'h0000);
    chk("mid_rst_imem_addr",  imem_addr,       16'h0000);
    chk("mid_rst_inst_valid", 16'(inst_valid), 16'h0000);
    chk("mid_rst_inst",       inst,            16'h0000);
    chk("mid_rst_inst_pc",    inst_pc,         16'h0000);
    chk("mid_rst_pc",         pc,              16'h0000);
    model_reset();
    adv();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("post_rst_empty", 16'(inst_valid), 16'h0000);
      adv();
    end

    // Randomized run against the model.
    for (int n = 0; n < 1500; n++) begin
      apply($urandom_range(0, 4) == 0,
            $urandom_range(0, 29) == 0,
            16'($urandom),
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) < 7);
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
